// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: default widths,
// FSM state encoding and small state-decode helpers.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // 3-bit state encoding; IDLE is the reset state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_I = 3'd1,
        ST_WAIT_D = 3'd2,
        ST_RESP_I = 3'd3,
        ST_RESP_D = 3'd4
    } arb_state_e;

    // True while a memory transaction is outstanding; the only states in
    // which a mem_done pulse is legal.
    function automatic logic is_wait_state(input arb_state_e st);
        return (st == ST_WAIT_I) || (st == ST_WAIT_D);
    endfunction

endpackage

// File: rtl/mem_arbiter_fsm.sv
// Arbitration state machine: fixed data-over-fetch priority, one
// transaction at a time, registered mem_en / done pulses and the sticky
// protocol error flag. Grant and capture strobes are exported so the top
// level can load the transaction registers and capture read data.
module mem_arbiter_fsm
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    input  logic mem_done,
    output logic grant_i,
    output logic grant_d,
    output logic cap_i,
    output logic cap_d,
    output logic mem_en,
    output logic i_done,
    output logic d_done,
    output logic err
);

    arb_state_e state_r;
    logic       mem_en_r;
    logic       i_done_r;
    logic       d_done_r;
    logic       err_r;

    logic       grant_i_s;
    logic       grant_d_s;
    logic       cap_i_s;
    logic       cap_d_s;

    // Decode grants (IDLE only, data side first) and read-data capture strobes
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        cap_i_s   = 1'b0;
        cap_d_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (d_req) begin
                    grant_d_s = 1'b1;
                end else if (i_req) begin
                    grant_i_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                    grant_d_s = 1'b0;
                end
            end
            ST_WAIT_I: begin
                cap_i_s = mem_done;
            end
            ST_WAIT_D: begin
                cap_d_s = mem_done;
            end
            ST_RESP_I, ST_RESP_D: begin
                // No grant while the finishing requester drops its request.
                grant_i_s = 1'b0;
                grant_d_s = 1'b0;
            end
            default: begin
                grant_i_s = 1'b0;
                grant_d_s = 1'b0;
                cap_i_s   = 1'b0;
                cap_d_s   = 1'b0;
            end
        endcase
    end

    // State register plus registered start/done pulses and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            mem_en_r <= 1'b0;
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            // Start pulse lands in the first WAIT cycle, done in the RESP cycle.
            mem_en_r <= grant_i_s | grant_d_s;
            i_done_r <= cap_i_s;
            d_done_r <= cap_d_s;

            // A completion with nothing outstanding is a protocol violation,
            // including a stale one from a transaction abandoned by reset.
            if (mem_done && !is_wait_state(state_r)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (grant_d_s) begin
                        state_r <= ST_WAIT_D;
                    end else if (grant_i_s) begin
                        state_r <= ST_WAIT_I;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_I: begin
                    if (mem_done) begin
                        state_r <= ST_RESP_I;
                    end else begin
                        state_r <= ST_WAIT_I;
                    end
                end
                ST_WAIT_D: begin
                    if (mem_done) begin
                        state_r <= ST_RESP_D;
                    end else begin
                        state_r <= ST_WAIT_D;
                    end
                end
                ST_RESP_I, ST_RESP_D: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_i = grant_i_s;
    assign grant_d = grant_d_s;
    assign cap_i   = cap_i_s;
    assign cap_d   = cap_d_s;
    assign mem_en  = mem_en_r;
    assign i_done  = i_done_r;
    assign d_done  = d_done_r;
    assign err     = err_r;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the single-ported unified memory shared by
// instruction fetch and the memory stage. Holds the transaction address,
// write data and read-data capture registers and forms the stall signals;
// sequencing lives in mem_arbiter_fsm.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              if_stall,
    output logic              mem_stall,
    output logic              err
);

    logic              grant_i_s;
    logic              grant_d_s;
    logic              cap_i_s;
    logic              cap_d_s;
    logic              mem_en_s;
    logic              i_done_s;
    logic              d_done_s;
    logic              err_s;

    logic              mem_wr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    mem_arbiter_fsm u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .d_req    (d_req),
        .mem_done (mem_done),
        .grant_i  (grant_i_s),
        .grant_d  (grant_d_s),
        .cap_i    (cap_i_s),
        .cap_d    (cap_d_s),
        .mem_en   (mem_en_s),
        .i_done   (i_done_s),
        .d_done   (d_done_s),
        .err      (err_s)
    );

    // Latch the granted request's command; held until the next grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            if (grant_d_s) begin
                mem_wr_r    <= d_wr;
                mem_addr_r  <= d_addr;
                mem_wdata_r <= d_wdata;
            end else if (grant_i_s) begin
                // Fetch is always a read; write data is left untouched.
                mem_wr_r    <= 1'b0;
                mem_addr_r  <= i_addr;
                mem_wdata_r <= mem_wdata_r;
            end else begin
                mem_wr_r    <= mem_wr_r;
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Capture returning read data into the owning requester's register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r <= {DATA_W{1'b0}};
        end else begin
            if (cap_i_s) begin
                i_rdata_r <= mem_rdata;
            end else begin
                i_rdata_r <= i_rdata_r;
            end
            // Writes complete without disturbing the last read value.
            if (cap_d_s && !mem_wr_r) begin
                d_rdata_r <= mem_rdata;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    // Stalls drop in the done cycle so the pipeline advances exactly then.
    assign if_stall  = i_req & ~i_done_s;
    assign mem_stall = d_req & ~d_done_s;

    assign i_done    = i_done_s;
    assign d_done    = d_done_s;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign mem_en    = mem_en_s;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign err       = err_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized requesters against a reactive variable-latency memory.
// A timestamp-based transaction model predicts every output each cycle.
module tb_mem_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int NEVER = 32'h3fff_ffff;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          i_req     = 1'b0;
    logic [AW-1:0] i_addr    = 16'h0000;
    logic          d_req     = 1'b0;
    logic          d_wr      = 1'b0;
    logic [AW-1:0] d_addr    = 16'h0000;
    logic [DW-1:0] d_wdata   = 16'h0000;
    logic [DW-1:0] mem_rdata = 16'h0000;
    logic          mem_done  = 1'b0;

    logic          i_done;
    logic [DW-1:0] i_rdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          if_stall;
    logic          mem_stall;
    logic          err;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .if_stall(if_stall), .mem_stall(mem_stall), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // memory responder
    int            lat        = 2;
    bit            random_lat = 1'b0;
    int            done_at    = -1;
    logic [DW-1:0] rd_next    = 16'h0000;

    // transaction model: grant cycle g, memory completion cycle m
    logic          m_txn    = 1'b0;
    int            m_g      = -100;
    int            m_m      = NEVER;
    logic          m_who_d  = 1'b0;
    logic          m_wr     = 1'b0;
    logic [AW-1:0] m_addr   = 16'h0000;
    logic [DW-1:0] m_wdata  = 16'h0000;
    logic [DW-1:0] m_irdata = 16'h0000;
    logic [DW-1:0] m_drdata = 16'h0000;
    logic          m_err    = 1'b0;
    logic          e_en, e_id, e_dd;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%h expected=0x%h", name, cyc, act, exp);
        end
    endtask

    // Apply the inputs of cycle k (= cyc) to the transaction model.
    task automatic model_edge();
        int   k;
        logic free;
        k = cyc;
        if (!rst_n) begin
            m_txn = 1'b0; m_g = -100; m_m = NEVER; m_wr = 1'b0;
            m_addr = 16'h0000; m_wdata = 16'h0000;
            m_irdata = 16'h0000; m_drdata = 16'h0000; m_err = 1'b0;
        end else begin
            // arbiter is free two cycles after memory completion (done cycle in between)
            free = !m_txn || (m_m != NEVER && k >= m_m + 2);
            if (mem_done) begin
                if (m_txn && m_m == NEVER && k > m_g) begin
                    m_m = k;
                    if (!m_who_d) m_irdata = mem_rdata;
                    else if (!m_wr) m_drdata = mem_rdata;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (free && (d_req || i_req)) begin
                m_txn = 1'b1; m_g = k; m_m = NEVER; m_who_d = d_req;
                if (d_req) begin
                    m_wr = d_wr; m_addr = d_addr; m_wdata = d_wdata;
                end else begin
                    m_wr = 1'b0; m_addr = i_addr;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        if (mem_en === 1'b1) begin
            if (random_lat) begin
                lat     = $urandom_range(1, 4);
                rd_next = 16'($urandom);
            end
            done_at = cyc + lat;
        end
        mem_done  = (cyc == done_at);
        mem_rdata = (cyc == done_at) ? rd_next : 16'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            e_en = m_txn && (m_g == cyc - 1);
            e_id = m_txn && (m_m == cyc - 1) && !m_who_d;
            e_dd = m_txn && (m_m == cyc - 1) && m_who_d;
            chk1 ("mem_en",    mem_en,    e_en);
            chk1 ("mem_wr",    mem_wr,    m_wr);
            chk16("mem_addr",  mem_addr,  m_addr);
            chk16("mem_wdata", mem_wdata, m_wdata);
            chk1 ("i_done",    i_done,    e_id);
            chk1 ("d_done",    d_done,    e_dd);
            chk16("i_rdata",   i_rdata,   m_irdata);
            chk16("d_rdata",   d_rdata,   m_drdata);
            chk1 ("err",       err,       m_err);
            chk1 ("if_stall",  if_stall,  i_req & ~e_id);
            chk1 ("mem_stall", mem_stall, d_req & ~e_dd);
        end
    end

    initial begin
        // reset state
        rst_n = 1'b0;
        idle(2);
        chk_en = 1'b1;
        @(negedge clk);
        chk1 ("rst_mem_en", mem_en, 1'b0);
        chk1 ("rst_mem_wr", mem_wr, 1'b0);
        chk16("rst_mem_addr", mem_addr, 16'h0000);
        chk16("rst_i_rdata", i_rdata, 16'h0000);
        chk1 ("rst_err", err, 1'b0);
        chk1 ("rst_if_stall", if_stall, 1'b0);
        step();
        rst_n = 1'b1;
        idle(2);

        // single fetch, L=2
        lat = 2; random_lat = 1'b0; rd_next = 16'hBEEF;
        step(); i_req = 1'b1; i_addr = 16'h0040;
        @(negedge clk); chk1("t1_if_stall_c0", if_stall, 1'b1);
        step(); @(negedge clk);
        chk1("t1_mem_en_c1", mem_en, 1'b1);
        chk16("t1_mem_addr_c1", mem_addr, 16'h0040);
        chk1("t1_mem_wr_c1", mem_wr, 1'b0);
        step(); @(negedge clk); chk1("t1_mem_en_c2", mem_en, 1'b0);
        step(); @(negedge clk);
        chk1("t1_if_stall_c3", if_stall, 1'b1);
        chk1("t1_i_done_c3", i_done, 1'b0);
        step(); @(negedge clk);
        chk1("t1_i_done_c4", i_done, 1'b1);
        chk16("t1_i_rdata_c4", i_rdata, 16'hBEEF);
        chk1("t1_if_stall_c4", if_stall, 1'b0);
        #1 i_req = 1'b0;
        step(); @(negedge clk); chk1("t1_i_done_c5", i_done, 1'b0);
        idle(3);

        // simultaneous requests, L=1: data write wins
        lat = 1; rd_next = 16'hC0DE;
        step();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h2000; d_wdata = 16'h1234;
        i_req = 1'b1; i_addr = 16'h0010;
        step(); @(negedge clk);
        chk1("t2_mem_en_c1", mem_en, 1'b1);
        chk16("t2_mem_addr_c1", mem_addr, 16'h2000);
        chk1("t2_mem_wr_c1", mem_wr, 1'b1);
        chk16("t2_mem_wdata_c1", mem_wdata, 16'h1234);
        step();
        step(); @(negedge clk);
        chk1("t2_d_done_c3", d_done, 1'b1);
        chk1("t2_mem_en_c3", mem_en, 1'b0);
        #1 d_req = 1'b0; d_wr = 1'b0;
        step(); @(negedge clk); chk1("t2_mem_en_c4", mem_en, 1'b0);
        step(); @(negedge clk);
        chk1("t2_mem_en_c5", mem_en, 1'b1);
        chk16("t2_mem_addr_c5", mem_addr, 16'h0010);
        chk1("t2_mem_wr_c5", mem_wr, 1'b0);
        step();
        step(); @(negedge clk);
        chk1("t2_i_done_c7", i_done, 1'b1);
        chk16("t2_i_rdata_c7", i_rdata, 16'hC0DE);
        chk16("t2_d_rdata_c7", d_rdata, 16'h0000);
        #1 i_req = 1'b0;
        idle(3);

        // data read, L=3, request dropped right after grant
        lat = 3; rd_next = 16'hA5A5;
        step(); d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h3FFE;
        step(); @(negedge clk);
        chk1("t3_mem_en_c1", mem_en, 1'b1);
        chk16("t3_mem_addr_c1", mem_addr, 16'h3FFE);
        step(); d_req = 1'b0;
        for (int t = 3; t <= 4; t++) begin
            step(); @(negedge clk);
            chk1("t3_mem_wr_wait", mem_wr, 1'b0);
            chk1("t3_d_done_early", d_done, 1'b0);
        end
        step(); @(negedge clk);
        chk1("t3_d_done_c5", d_done, 1'b1);
        chk16("t3_d_rdata_c5", d_rdata, 16'hA5A5);
        idle(2); @(negedge clk);
        chk16("t3_d_rdata_held", d_rdata, 16'hA5A5);
        chk1("t3_mem_wr_after", mem_wr, 1'b0);

        // back-to-back reads with d_req held across RESP, L=1
        lat = 1; rd_next = 16'h1357;
        step(); d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
        for (int t = 1; t <= 15; t++) begin
            step(); @(negedge clk);
            chk1("t4_mem_en", mem_en, (t % 4) == 1);
            chk1("t4_d_done", d_done, (t % 4) == 3);
            if (t == 15) begin
                #1 d_req = 1'b0;
            end
        end
        idle(3);

        // reset in the second WAIT_D cycle, then a stale mem_done
        lat = 3; rd_next = 16'h7777;
        step(); d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h1111;
        step(); @(negedge clk); chk1("t5_mem_en_c1", mem_en, 1'b1);
        step(); rst_n = 1'b0; d_req = 1'b0;
        step(); @(negedge clk);
        chk1("t5_mem_en_rst", mem_en, 1'b0);
        chk16("t5_mem_addr_rst", mem_addr, 16'h0000);
        chk1("t5_d_done_rst", d_done, 1'b0);
        chk16("t5_d_rdata_rst", d_rdata, 16'h0000);
        chk1("t5_err_rst", err, 1'b0);
        #1 rst_n = 1'b1;
        step(); @(negedge clk);
        chk1("t5_err_c4", err, 1'b0);
        step(); @(negedge clk);
        chk1("t5_err_c5", err, 1'b1);
        chk1("t5_d_done_c5", d_done, 1'b0);
        idle(5); @(negedge clk);
        chk1("t5_err_sticky", err, 1'b1);
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        @(negedge clk); chk1("t5_err_cleared", err, 1'b0);

        // stray mem_done in IDLE
        step(); mem_done = 1'b1;
        step(); @(negedge clk);
        chk1("t6_err", err, 1'b1);
        chk1("t6_mem_en", mem_en, 1'b0);
        chk1("t6_i_done", i_done, 1'b0);
        chk1("t6_d_done", d_done, 1'b0);
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;

        // randomized requesters against a random-latency memory
        random_lat = 1'b1;
        repeat (3000) begin
            step();
            if (!i_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    i_req = 1'b1; i_addr = 16'($urandom);
                end
            end else if (i_done) begin
                if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                else i_addr = 16'($urandom);
            end
            if (!d_req) begin
                if ($urandom_range(0, 4) == 0) begin
                    d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
                    d_addr = 16'($urandom); d_wdata = 16'($urandom);
                end
            end else if (d_done) begin
                if ($urandom_range(0, 1) == 0) begin
                    d_req = 1'b0;
                end else begin
                    d_wr = 1'($urandom_range(0, 1));
                    d_addr = 16'($urandom); d_wdata = 16'($urandom);
                end
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        idle(10);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-ported unified memory shared by instruction fetch and the memory stage. Grants one transaction at a time, drives the variable-latency memory handshake, captures read data, and generates the fetch and memory-stage stall signals. Sits between the fetch/memory stages and the memory model. Data-side accesses take fixed priority over fetch.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- i_req  in  1  fetch read request; held until i_done
- i_addr  in  ADDR_W  fetch address; stable while i_req
- i_done  out  1  one-cycle completion pulse
- i_rdata  out  DATA_W  registered fetch data; valid while i_done, then held
- d_req  in  1  memory-stage request; held until d_done
- d_wr  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  ADDR_W  data address; stable while d_req
- d_wdata  in  DATA_W  write data; stable while d_req
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  registered read data; updated only by reads
- mem_en  out  1  one-cycle transaction start pulse
- mem_wr  out  1  write enable; held for the whole transaction
- mem_addr  out  ADDR_W  registered address; held for the whole transaction
- mem_wdata  out  DATA_W  registered write data; held for the whole transaction
- mem_rdata  in  DATA_W  read data; valid only in the mem_done cycle
- mem_done  in  1  one-cycle completion pulse, at least 1 cycle after mem_en
- if_stall  out  1  i_req & ~i_done
- mem_stall  out  1  d_req & ~d_done
- err  out  1  sticky protocol error

## Operation
- States: IDLE, WAIT_I, WAIT_D, RESP_I, RESP_D.
- IDLE with d_req: latch d_wr, d_addr, d_wdata; go to WAIT_D. Otherwise, IDLE with i_req: latch i_addr with mem_wr=0; go to WAIT_I. With neither request, stay in IDLE.
- If both requests are present in IDLE, D wins. I remains pending and is granted in the first IDLE cycle after RESP_D.
- mem_en=1 only in the first cycle of WAIT_x.
- WAIT_x stays in WAIT_x until mem_done. At that edge, capture mem_rdata into i_rdata or d_rdata (d_rdata only if the access is a read), then go to RESP_x.
- RESP_x asserts x_done for that cycle only, then unconditionally goes to IDLE. No grant is made in RESP_x, so the completing requester has one cycle to drop its request.
- A request dropped after grant still completes; done still pulses.
- Requests and their inputs are ignored outside IDLE.
- mem_done in IDLE or RESP_x sets err. err clears only on reset.
- Reset values: state IDLE. mem_en, mem_wr, i_done, d_done, err, if_stall/mem_stall (given requests low) are 0. mem_addr, mem_wdata, i_rdata, d_rdata are 0.
- Reset mid-transaction: the transaction is abandoned with no done pulse. The memory must share rst_n. A stale mem_done after reset sets err.

## Timing
- Request sampled in IDLE at cycle 0 → mem_en and mem_addr valid in cycle 1.
- Memory latency L ≥ 1: mem_done arrives in cycle 1+L.
- x_done and x_rdata are valid in cycle 2+L; the state returns to IDLE in cycle 3+L.
- Minimum back-to-back period is L+3 cycles per transaction.
- Stall outputs are combinational from registered done and the request inputs: high from the request cycle through cycle 1+L, low in the done cycle.
- All other outputs are registered.

## Structure
- Shared defines header mem_arb_defs.vh holds the state encodings (3-bit) and the ADDR_W/DATA_W defaults.
- One natural sub-module: mem_arb_fsm, covering the state register, next-state and priority logic, and the mem_en/done pulse generation. The top level holds the address, data and capture registers and the stall logic.

## Test plan
- Single fetch, L=2: i_req, i_addr=0x0040 at c0 → mem_en c1 (addr 0x0040, wr 0); memory returns mem_done c3 with mem_rdata=0xBEEF → i_done c4 with i_rdata=0xBEEF; if_stall high c0–c3, low c4.
- Simultaneous requests, L=1, d write 0x2000/0x1234 and i read 0x0010 → first mem_en c1 (addr 0x2000, wr 1, wdata 0x1234); d_done c3; second mem_en c5 (addr 0x0010); i_done c7; d_rdata unchanged.
- Data read, L=3, d_addr=0x3FFE, mem_rdata=0xA5A5 → d_done c5, d_rdata=0xA5A5 held after d_req drops; mem_wr=0 throughout.
- Back-to-back d reads with d_req held high across RESP, L=1 → mem_en pulses exactly 4 cycles apart; no grant in RESP cycles.
- rst_n low in the second WAIT_D cycle → next cycle state IDLE, all outputs 0, no d_done; a following mem_done sets err=1, which stays set until the next reset.
- Stray mem_done in IDLE → err=1 next cycle; other outputs unaffected.
